// File: rtl/credit_rx_buffer.sv
// rtl/credit_rx_buffer.sv - credit-protocol receive FIFO with registered head output and credit return
// One credit pulse per consumed entry; overflow is a sticky error for beats sent without credit.
module credit_rx_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     consume,
   output logic                     credit_out,
   output logic [WIDTH-1:0]         data_out,
   output logic                     valid_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic [AW-1:0]    head_next;
   logic [CW-1:0]    count_after_deq;
   logic             deq;
   logic             enq;
   logic             new_head_is_tail;

   assign valid_out        = (count != '0);
   assign deq              = consume & valid_out;
   assign enq              = valid_in & ((count != FULL) | deq);
   assign head_next        = deq ? head + AW'(1) : head;
   assign count_after_deq  = count - CW'(deq);
   // The incoming beat becomes the head when nothing older survives this edge.
   assign new_head_is_tail = enq & (count_after_deq == '0);

   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         credit_out <= 1'b0;
         overflow   <= 1'b0;
         data_out   <= '0;
      end else begin
         head       <= head_next;
         credit_out <= deq;
         count      <= count + CW'(enq) - CW'(deq);
         if (enq) begin
            tail <= tail + AW'(1);
         end
         if (valid_in & ~enq) begin
            overflow <= 1'b1;
         end
         // data_out is registered so it never depends combinationally on data_in.
         if (new_head_is_tail) begin
            data_out <= data_in;
         end else if (count_after_deq != '0) begin
            data_out <= mem[head_next];
         end
      end
   end

endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb/tb_credit_rx_buffer.sv - scoreboard bench for credit_rx_buffer
// A queue-based reference predicts occupancy, credits and overflow; a negedge monitor checks the DUT.
module tb_credit_rx_buffer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_in;
   logic [WIDTH-1:0] data_in;
   logic             consume;
   logic             credit_out;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic [2:0]       count;
   logic             overflow;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] exp_q[$];
   int   m_count   = 0;
   bit   m_credit  = 1'b0;
   bit   m_ovf     = 1'b0;
   bit   started   = 1'b0;
   int   m_deq_tot = 0;
   int   credit_tot = 0;

   credit_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .consume    (consume),
      .credit_out (credit_out),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic c, input logic r);
      valid_in = v;
      data_in  = d;
      consume  = c;
      rst      = r;
      @(posedge clk);
      #1;
   endtask

   // Reference: occupancy and flags from the protocol rules; accepted beats join the scoreboard.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            exp_q.delete();
            m_count  = 0;
            m_credit = 1'b0;
            m_ovf    = 1'b0;
            started  = 1'b1;
         end else if (started) begin
            bit d, e;
            d = consume && (m_count > 0);
            e = valid_in && ((m_count < DEPTH) || d);
            if (valid_in && !e) m_ovf = 1'b1;
            if (e) exp_q.push_back(data_in);
            m_count  = m_count + int'(e) - int'(d);
            m_credit = d;
            if (d) m_deq_tot++;
         end
      end
   end

   // Monitor: compares status every cycle and pops the scoreboard when the head is consumed.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("count", 32'(count), 32'(m_count));
            chk("valid_out", 32'(valid_out), 32'(m_count != 0));
            chk("credit_out", 32'(credit_out), 32'(m_credit));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (credit_out) credit_tot++;
            if (valid_out && exp_q.size() > 0) begin
               chk("data_out", data_out, exp_q[0]);
               if (consume && !rst) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      valid_in = 1'b0;
      data_in  = '0;
      consume  = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      // reset then idle
      step(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      // single beat
      step(1, 32'hDEADBEEF, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      // fill, overflow, drain
      for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0);
      step(1, 5, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      // full with simultaneous enqueue and dequeue
      for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0);
      step(1, 9, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      // wrap-around streaming
      step(1, 0, 0, 0);
      for (int i = 1; i < 20; i++) step(1, 32'(i), 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      // reset mid-operation
      for (int i = 0; i < 3; i++) step(1, 32'(100 + i), 0, 0);
      step(0, 0, 1, 1);
      step(1, 7, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(99) < 60) ? 1'b1 : 1'b0, $urandom,
              ($urandom_range(99) < 50) ? 1'b1 : 1'b0,
              ($urandom_range(399) == 0) ? 1'b1 : 1'b0);
      end
      step(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("credit_total", 32'(credit_tot), 32'(m_deq_tot));
      chk("drained", 32'(exp_q.size()), 32'(m_count));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/credit_rx_buffer.md
Name: credit_rx_buffer

Overview:
Receiving end of the switch-network credit protocol driven by ff_stage-style senders.
- Accepts valid/data beats from an upstream link into a DEPTH-entry FIFO.
- Presents the head entry to the consuming functional unit.
- Returns exactly one credit_out pulse upstream per entry consumed.
- The sender resets its credit counter to DEPTH, so this block never issues initial credits.

Parameters:
WIDTH, `PATH_WIDTH (config.v), data beat width
DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_in  input  1  upstream beat valid
data_in  input  WIDTH  upstream beat data
consume  input  1  consumer pops head this cycle; effective only when valid_out=1
credit_out  output  1  one-cycle credit return pulse to upstream
data_out  output  WIDTH  head entry (first-word-fall-through)
valid_out  output  1  FIFO non-empty
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky error: beat arrived with no free slot

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - Pointers and count go to 0.
  - credit_out=0, valid_out=0, overflow=0, data_out=0.
  - Storage contents are don't-care.
  - rst overrides all same-cycle enqueue and dequeue activity; in-flight entries are discarded and no credits are returned for them.
- Enqueue:
  - Occurs at a posedge with valid_in=1 and (count<DEPTH, or a dequeue in the same cycle).
  - data_in is written at the tail; the tail pointer wraps modulo DEPTH.
- Dequeue:
  - Occurs at a posedge with consume=1 and valid_out=1; the head pointer wraps modulo DEPTH.
  - consume with an empty FIFO is ignored: no pointer change, no credit.
- Latency:
  - A beat enqueued into an empty FIFO at edge N has valid_out=1 and data_out equal to that beat from edge N on, i.e. visible in cycle N+1.
  - There is no combinational path from data_in to data_out.
- data_out:
  - Always equals the entry at the head pointer.
  - Holds its last value when the FIFO is empty; the bench must not check it then.
- Credit return:
  - credit_out is a registered signal.
  - It is 1 in the cycle immediately after each dequeue edge and 0 otherwise.
  - Total credit pulses equal total dequeues since reset.
- Occupancy:
  - count is incremented by an enqueue alone, decremented by a dequeue alone, and unchanged when both occur in the same cycle.
  - count never exceeds DEPTH and never goes below 0.
- Full plus simultaneous enqueue and dequeue:
  - The beat is accepted and count stays DEPTH.
  - overflow is not set.
- Overflow condition:
  - valid_in=1 while count==DEPTH with no dequeue in that cycle.
  - The beat is dropped, overflow goes to 1 and stays 1 until rst.
  - FIFO contents are unaffected.
- Empty plus simultaneous enqueue and dequeue:
  - The dequeue is ignored, since valid_out was 0.
  - The enqueue proceeds and count becomes 1.
- Ordering is strict FIFO; no reordering or bypass.

Test Plan:
- Reset then idle: rst=1 for 1 cycle → credit_out=0, valid_out=0, count=0, overflow=0 held for 5 cycles.
- Single beat: valid_in=1, data_in=32'hDEADBEEF for 1 cycle, consume=0 → next cycle valid_out=1, data_out=DEADBEEF, count=1. Then consume=1 for 1 cycle → count=0, credit_out=1 for exactly the following cycle.
- Fill and overflow (DEPTH=4):
  - Enqueue 1,2,3,4 on consecutive cycles → count=4, overflow=0.
  - Enqueue 5 with consume=0 → overflow=1 (sticky), count=4.
  - Drain → data_out sequence 1,2,3,4 with 4 credit pulses; value 5 never appears.
- Full with simultaneous enqueue and dequeue: fill with 1..4, then valid_in=1, data_in=9, consume=1 → count=4, overflow=0, one credit pulse. Drain order is 2,3,4,9.
- Wrap-around streaming: 20 beats 0..19 enqueued and consumed every cycle after the first → output order 0..19, count stays ≤2, 20 credit pulses total, overflow=0.
- Reset mid-operation: 3 entries queued, assert rst together with consume=1 → next cycle count=0, valid_out=0, credit_out=0. A following enqueue of 7 is read back as 7.
